// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the microprogram sequencer (master) and alu_muldiv_seq (slave).
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             busy;

  modport master (
    output in_valid, A, B, Control, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, busy
  );

  modport slave (
    input  in_valid, A, B, Control, out_ready,
    output in_ready, out_valid, ALUResult, Zero, busy
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Registered RV32IM-style ALU with valid/ready handshake; the iterative radix-2
// multiply/divide datapath is present only when ALU_MULDIV_EN is defined.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave io_bus
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

`ifdef ALU_MULDIV_EN
  localparam logic [3:0]       OP_MUL  = 4'b1010;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_accept;
  logic             w_iter;
  logic             w_last;
  logic [WIDTH-1:0] w_fast;

  function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] sra;
    logic [SHW-1:0]          sh;
    sa  = a;
    sb  = b;
    sh  = b[SHW-1:0];
    sra = sa >>> sh;
    case (op)
      OP_ADD:  alu_simple = a + b;
      OP_SUB:  alu_simple = a - b;
      OP_AND:  alu_simple = a & b;
      OP_OR:   alu_simple = a | b;
      OP_XOR:  alu_simple = a ^ b;
      OP_SLT:  alu_simple = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLL:  alu_simple = a << sh;
      OP_SRL:  alu_simple = a >> sh;
      OP_SRA:  alu_simple = sra;
      OP_SLTU: alu_simple = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_simple = '0;
    endcase
  endfunction

  assign io_bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.ALUResult = r_result;
  assign io_bus.Zero      = r_zero;
  assign w_accept         = io_bus.in_valid && io_bus.in_ready;

`ifdef ALU_MULDIV_EN
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    neg_if = neg ? -v : v;
  endfunction

  logic             w_is_md, w_is_div, w_b_zero, w_ovf, w_special, w_sgn_a, w_sgn_b;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH-1:0] r_acc, r_lo, r_opa;
  logic [SHW-1:0]   r_cnt;
  logic             r_is_div, r_sel_hi, r_neg_q, r_neg_r;
  logic [WIDTH:0]   w_sum, w_shl, w_diff;
  logic [WIDTH-1:0] w_acc_nxt, w_lo_nxt, w_raw, w_md_res;

  // Accept-time decode: divide-by-zero and signed overflow finish without iterating
  assign w_is_md   = (io_bus.Control >= OP_MUL);
  assign w_is_div  = (io_bus.Control[3:2] == 2'b11);
  assign w_b_zero  = (io_bus.B == '0);
  assign w_ovf     = io_bus.Control[1] && (io_bus.A == MIN_NEG) && (io_bus.B == '1);
  assign w_special = w_is_div && (w_b_zero || w_ovf);
  assign w_sgn_a   = io_bus.Control[1] && io_bus.A[WIDTH-1];
  assign w_sgn_b   = io_bus.Control[1] && io_bus.B[WIDTH-1];
  assign w_iter    = w_is_md && !w_special;

  always_comb begin
    w_spec_res = '0;
    if (w_b_zero) w_spec_res = io_bus.Control[0] ? io_bus.A : '1;
    else          w_spec_res = io_bus.Control[0] ? '0 : io_bus.A;
  end

  assign w_fast = w_special ? w_spec_res : alu_simple(io_bus.Control, io_bus.A, io_bus.B);

  // One shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle
  assign w_sum  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opa} : '0);
  assign w_shl  = {r_acc, r_lo[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, r_opa};

  always_comb begin
    w_acc_nxt = r_acc;
    w_lo_nxt  = r_lo;
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt  = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shl[WIDTH-1:0];
        w_lo_nxt  = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_sum[WIDTH:1];
      w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_last   = (r_state == S_CALC) && (r_cnt == '0);
  assign w_raw    = r_sel_hi ? w_acc_nxt : w_lo_nxt;
  assign w_md_res = neg_if(r_sel_hi ? r_neg_r : r_neg_q, w_raw);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cnt    <= SHW'(WIDTH-1);
      r_acc    <= '0;
      r_is_div <= w_is_div;
      r_sel_hi <= io_bus.Control[0];
      if (w_is_div) begin
        r_lo    <= neg_if(w_sgn_a, io_bus.A);
        r_opa   <= neg_if(w_sgn_b, io_bus.B);
        r_neg_q <= w_sgn_a ^ w_sgn_b;
        r_neg_r <= w_sgn_a;
      end else begin
        r_lo    <= io_bus.B;
        r_opa   <= io_bus.A;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign io_bus.busy = (r_state == S_CALC);
`else
  assign w_iter      = 1'b0;
  assign w_last      = 1'b0;
  assign w_fast      = alu_simple(io_bus.Control, io_bus.A, io_bus.B);
  assign io_bus.busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_iter ? state_e'(2'd1) : S_DONE;
`ifdef ALU_MULDIV_EN
      S_CALC: if (w_last) w_state_nxt = S_DONE;
`endif
      S_DONE: if (io_bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept && !w_iter) begin
      r_result <= w_fast;
      r_zero   <= (w_fast == '0);
    end
`ifdef ALU_MULDIV_EN
    else if (w_last) begin
      r_result <= w_md_res;
      r_zero   <= (w_md_res == '0);
    end
`endif
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq; expectations follow ALU_MULDIV_EN when defined.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULHU= 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [3:0] OP_REM  = 4'b1111;

`ifdef ALU_MULDIV_EN
  localparam int MD_LAT = W + 1;
`else
  localparam int MD_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_muldiv_seq_if #(.WIDTH(W)) u_if ();
  alu_muldiv_seq #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .io_bus(u_if));

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    u_if.Control  = op;
    u_if.A        = a;
    u_if.B        = b;
    u_if.in_valid = 1'b1;
    chk_eq("in_ready_at_issue", u_if.in_ready, 1);
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    u_if.A        = 32'hDEAD_BEEF;
    u_if.B        = 32'h1234_5678;
    u_if.Control  = OP_SUB;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!u_if.out_valid && lat < 200) begin
      if (u_if.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk_eq("consume_out_valid", u_if.out_valid, 0);
    chk_eq("consume_in_ready", u_if.in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat,
                     output int bcnt);
    int lat;
    send(op, a, b);
    wait_done(lat, bcnt);
    chk_eq({tag, "_lat"}, lat, exp_lat);
    chk_eq({tag, "_res"}, u_if.ALUResult, exp);
    chk_eq({tag, "_zero"}, u_if.Zero, (exp == '0));
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc;
    int lat;
    logic [W-1:0] held;

    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.A         = '0;
    u_if.B         = '0;
    u_if.Control   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_in_ready", u_if.in_ready, 0);
    chk_eq("rst_out_valid", u_if.out_valid, 0);
    chk_eq("rst_result", u_if.ALUResult, 0);
    chk_eq("rst_zero", u_if.Zero, 1);
    chk_eq("rst_busy", u_if.busy, 0);
    rst_n = 1'b1;
    #1;
    chk_eq("post_rst_in_ready", u_if.in_ready, 1);

    run("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, bc);
    run("sra",      OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 1, bc);
    run("sub",      OP_SUB,  32'h3,         32'h5,         32'hFFFF_FFFE, 1, bc);
    run("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1, bc);
    run("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, bc);
    run("sll",      OP_SLL,  32'h1,         32'h21,        32'h2,         1, bc);
    run("srl",      OP_SRL,  32'h8000_0000, 32'h1F,        32'h1,         1, bc);
    run("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, bc);
    run("or",       OP_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1, bc);

`ifdef ALU_MULDIV_EN
    run("mulhu",    OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MD_LAT, bc);
    chk_eq("mulhu_busy_cycles", bc, W);
    run("mul",      OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MD_LAT, bc);
    run("mul_b",    OP_MUL,  32'h0001_2345, 32'h100,       32'h0123_4500, MD_LAT, bc);
    run("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, MD_LAT, bc);
    run("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, MD_LAT, bc);
    run("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        MD_LAT, bc);
    run("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         MD_LAT, bc);
    run("divu_b0",  OP_DIVU, 32'd5,         32'h0,         32'hFFFF_FFFF, 1, bc);
    chk_eq("divu_b0_busy", bc, 0);
    run("remu_b0",  OP_REMU, 32'd5,         32'h0,         32'd5,         1, bc);
    run("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, bc);
    run("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, bc);
`else
    run("mulhu_off", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MD_LAT, bc);
    chk_eq("mulhu_off_busy", bc, 0);
    run("divu_off",  OP_DIVU,  32'd100,       32'd7,         32'h0, MD_LAT, bc);
    run("rem_off",   OP_REM,   32'hFFFF_FFF9, 32'h2,         32'h0, MD_LAT, bc);
`endif

    // Backpressure: result held for 5 cycles, a stray request is dropped
    send(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    wait_done(lat, bc);
    chk_eq("bp_res", u_if.ALUResult, 32'hFF00_FF00);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        u_if.in_valid = 1'b1;
        u_if.Control  = OP_ADD;
        u_if.A        = 32'h1;
        u_if.B        = 32'h1;
      end else begin
        u_if.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk_eq("bp_out_valid", u_if.out_valid, 1);
      chk_eq("bp_res_stable", u_if.ALUResult, 32'hFF00_FF00);
      chk_eq("bp_in_ready", u_if.in_ready, 0);
    end
    u_if.in_valid = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("bp_not_queued", u_if.out_valid, 0);
    chk_eq("bp_res_kept", u_if.ALUResult, 32'hFF00_FF00);

    // Reset in the middle of an operation aborts it
`ifdef ALU_MULDIV_EN
    send(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    chk_eq("abort_busy_before", u_if.busy, 1);
    held = u_if.ALUResult;
    chk_eq("abort_result_unchanged", held, 32'hFF00_FF00);
`else
    send(OP_ADD, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    chk_eq("abort_valid_before", u_if.out_valid, 1);
    chk_eq("abort_res_before", u_if.ALUResult, 32'd7);
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_eq("abort_out_valid", u_if.out_valid, 0);
    chk_eq("abort_result", u_if.ALUResult, 0);
    chk_eq("abort_zero", u_if.Zero, 1);
    chk_eq("abort_busy", u_if.busy, 0);
    chk_eq("abort_in_ready", u_if.in_ready, 0);
    rst_n = 1'b1;
    #1;
    run("sub_after_abort", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, bc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
